// File: rtl/redirect_ctrl_pkg.sv
// Shared types for the redirect controller: redirect causes, FSM states and
// the saturating event-counter helper.
`ifndef ALEN
`define ALEN 32
`endif

package redirect_ctrl_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_FENCE      = 2'd1,
      CAUSE_MISPREDICT = 2'd2,
      CAUSE_TRAP       = 2'd3
   } cause_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_e;

   localparam int CNT_W = 4;
   localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      logic [31:0] r;
      if (v == COUNT_MAX) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// Request/redirect bundle between the pipeline's redirect sources, the
// controller and the fetch unit.
`ifndef ALEN
`define ALEN 32
`endif

interface redirect_ctrl_if #(parameter int ALEN = `ALEN);
   logic            trap_valid;
   logic [ALEN-1:0] trap_target;
   logic            mispredict_valid;
   logic [ALEN-1:0] mispredict_target;
   logic            fence_valid;
   logic [ALEN-1:0] fence_target;
   logic            fetch_ready;
   logic            pipeline_flush;
   logic            fetch_redirect_valid;
   logic [ALEN-1:0] fetch_redirect_addr;
   logic [1:0]      fetch_redirect_cause;
   logic            busy;
   logic [31:0]     mispredict_count;

   modport slave (
      input  trap_valid, trap_target, mispredict_valid, mispredict_target,
             fence_valid, fence_target, fetch_ready,
      output pipeline_flush, fetch_redirect_valid, fetch_redirect_addr,
             fetch_redirect_cause, busy, mispredict_count
   );

   modport master (
      output trap_valid, trap_target, mispredict_valid, mispredict_target,
             fence_valid, fence_target, fetch_ready,
      input  pipeline_flush, fetch_redirect_valid, fetch_redirect_addr,
             fetch_redirect_cause, busy, mispredict_count
   );
endinterface

// File: rtl/redirect_ctrl_arb.sv
// Fixed-priority selector among the three redirect sources:
// trap beats mispredict beats fence.
`ifndef ALEN
`define ALEN 32
`endif

module redirect_arb
   import redirect_ctrl_pkg::*;
#(
   parameter int ALEN = `ALEN
) (
   input  logic            trap_valid_i,
   input  logic [ALEN-1:0] trap_target_i,
   input  logic            mispredict_valid_i,
   input  logic [ALEN-1:0] mispredict_target_i,
   input  logic            fence_valid_i,
   input  logic [ALEN-1:0] fence_target_i,
   output logic            req_valid_o,
   output logic [ALEN-1:0] req_target_o,
   output cause_e          req_cause_o
);

   // Pick the highest-priority valid request.
   always_comb begin
      req_valid_o  = 1'b0;
      req_target_o = {ALEN{1'b0}};
      req_cause_o  = CAUSE_NONE;
      if (trap_valid_i) begin
         req_valid_o  = 1'b1;
         req_target_o = trap_target_i;
         req_cause_o  = CAUSE_TRAP;
      end else if (mispredict_valid_i) begin
         req_valid_o  = 1'b1;
         req_target_o = mispredict_target_i;
         req_cause_o  = CAUSE_MISPREDICT;
      end else if (fence_valid_i) begin
         req_valid_o  = 1'b1;
         req_target_o = fence_target_i;
         req_cause_o  = CAUSE_FENCE;
      end else begin
         req_valid_o  = 1'b0;
         req_target_o = {ALEN{1'b0}};
         req_cause_o  = CAUSE_NONE;
      end
   end

endmodule

// File: rtl/redirect_ctrl.sv
// Redirect controller: arbitrates trap/mispredict/fence requests, holds the
// pipeline flush for a fixed number of cycles, then offers the redirect to fetch.
`ifndef ALEN
`define ALEN 32
`endif

module redirect_ctrl
   import redirect_ctrl_pkg::*;
#(
   parameter int ALEN         = `ALEN,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   redirect_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ALEN-1:0]  ADDR_MASK = {{(ALEN-1){1'b1}}, 1'b0};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ALEN-1:0]  addr_q, addr_d;
   cause_e           cause_q, cause_d;
   cause_e           cause_out_q, cause_out_d;
   logic             flush_q, flush_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [31:0]      mcount_q, mcount_d;

   logic             arb_valid_s;
   logic [ALEN-1:0]  arb_target_s;
   cause_e           arb_cause_s;

   redirect_arb #(.ALEN(ALEN)) u_arb (
      .trap_valid_i        (bus.trap_valid),
      .trap_target_i       (bus.trap_target),
      .mispredict_valid_i  (bus.mispredict_valid),
      .mispredict_target_i (bus.mispredict_target),
      .fence_valid_i       (bus.fence_valid),
      .fence_target_i      (bus.fence_target),
      .req_valid_o         (arb_valid_s),
      .req_target_o        (arb_target_s),
      .req_cause_o         (arb_cause_s)
   );

   // Next-state, latched redirect and output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      cause_d  = cause_q;
      mcount_d = mcount_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid_s) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_LOAD;
               addr_d  = arb_target_s & ADDR_MASK;
               cause_d = arb_cause_s;
               if (arb_cause_s == CAUSE_MISPREDICT) begin
                  mcount_d = sat_inc(mcount_q);
               end else begin
                  mcount_d = mcount_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            // Only a trap can preempt; younger mispredict/fence are being flushed.
            if (bus.trap_valid) begin
               cnt_d   = CNT_LOAD;
               addr_d  = bus.trap_target & ADDR_MASK;
               cause_d = CAUSE_TRAP;
            end else if (cnt_q == CNT_ZERO) begin
               state_d = ST_REDIRECT;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_REDIRECT: begin
            // A trap restarts the flush whether or not this handshake completes.
            if (bus.trap_valid) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_LOAD;
               addr_d  = bus.trap_target & ADDR_MASK;
               cause_d = CAUSE_TRAP;
            end else if (bus.fetch_ready) begin
               state_d = ST_IDLE;
               cause_d = CAUSE_NONE;
            end else begin
               state_d = ST_REDIRECT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            cause_d = CAUSE_NONE;
         end
      endcase

      flush_d = (state_d == ST_FLUSH);
      valid_d = (state_d == ST_REDIRECT);
      busy_d  = (state_d != ST_IDLE);
      if (valid_d) begin
         cause_out_d = cause_d;
      end else begin
         cause_out_d = CAUSE_NONE;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         addr_q      <= {ALEN{1'b0}};
         cause_q     <= CAUSE_NONE;
         cause_out_q <= CAUSE_NONE;
         flush_q     <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         mcount_q    <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         cause_q     <= cause_d;
         cause_out_q <= cause_out_d;
         flush_q     <= flush_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         mcount_q    <= mcount_d;
      end
   end

   assign bus.pipeline_flush       = flush_q;
   assign bus.fetch_redirect_valid = valid_q;
   assign bus.fetch_redirect_addr  = addr_q;
   assign bus.fetch_redirect_cause = cause_out_q;
   assign bus.busy                 = busy_q;
   assign bus.mispredict_count     = mcount_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: stimulus pushes expected redirects,
// a negedge monitor pops them on each fetch handshake.
`timescale 1ns/1ps

module tb_redirect_ctrl;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  cause;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   logic        prev_valid;
   logic [31:0] prev_addr;
   logic [1:0]  prev_cause;

   redirect_ctrl_if #(.ALEN(32)) bus ();

   redirect_ctrl #(.ALEN(32), .FLUSH_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_reqs();
      bus.trap_valid       = 1'b0;
      bus.mispredict_valid = 1'b0;
      bus.fence_valid      = 1'b0;
   endtask

   task automatic push(input logic [31:0] a, input logic [1:0] c);
      exp_t e;
      e.addr  = a;
      e.cause = c;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 40) begin
         tick();
         n++;
      end
      chk("idle_timeout", {63'd0, bus.busy}, 64'd0);
   endtask

   task automatic mispredict(input logic [31:0] t);
      bus.mispredict_valid  = 1'b1;
      bus.mispredict_target = t;
      tick();
      clear_reqs();
   endtask

   // Monitor: invariants every cycle, scoreboard pop on each handshake.
   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (bus.pipeline_flush && bus.fetch_redirect_valid) begin
            errors++;
            $display("FAIL excl: flush and valid both high");
         end
         checks++;
         if (!bus.fetch_redirect_valid && bus.fetch_redirect_cause != 2'd0) begin
            errors++;
            $display("FAIL cause_idle: got %0d expected 0", bus.fetch_redirect_cause);
         end
         if (bus.fetch_redirect_valid && prev_valid) begin
            checks++;
            if (bus.fetch_redirect_addr != prev_addr || bus.fetch_redirect_cause != prev_cause) begin
               errors++;
               $display("FAIL stable: got %0h/%0d expected %0h/%0d", bus.fetch_redirect_addr,
                        bus.fetch_redirect_cause, prev_addr, prev_cause);
            end
         end
         if (bus.fetch_redirect_valid && bus.fetch_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_redirect: got %0h/%0d expected none",
                        bus.fetch_redirect_addr, bus.fetch_redirect_cause);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (bus.fetch_redirect_addr != e.addr || bus.fetch_redirect_cause != e.cause) begin
                  errors++;
                  $display("FAIL redirect: got %0h/%0d expected %0h/%0d", bus.fetch_redirect_addr,
                           bus.fetch_redirect_cause, e.addr, e.cause);
               end
            end
         end
         prev_valid = bus.fetch_redirect_valid && !bus.fetch_ready;
         prev_addr  = bus.fetch_redirect_addr;
         prev_cause = bus.fetch_redirect_cause;
      end else begin
         prev_valid = 1'b0;
         prev_addr  = 32'd0;
         prev_cause = 2'd0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      clear_reqs();
      bus.trap_target       = 32'd0;
      bus.mispredict_target = 32'd0;
      bus.fence_target      = 32'd0;
      bus.fetch_ready       = 1'b1;
      tick();
      tick();
      chk("rst_flush", {63'd0, bus.pipeline_flush}, 64'd0);
      chk("rst_valid", {63'd0, bus.fetch_redirect_valid}, 64'd0);
      chk("rst_addr",  {32'd0, bus.fetch_redirect_addr}, 64'd0);
      chk("rst_cause", {62'd0, bus.fetch_redirect_cause}, 64'd0);
      chk("rst_busy",  {63'd0, bus.busy}, 64'd0);
      chk("rst_count", {32'd0, bus.mispredict_count}, 64'd0);
      rst = 1'b1;
      tick();

      // Basic mispredict with latency and ignored mispredict during flush.
      push(32'h0000_1000, 2'd2);
      mispredict(32'h0000_1000);
      chk("s1_flush_n1", {63'd0, bus.pipeline_flush}, 64'd1);
      chk("s1_count",    {32'd0, bus.mispredict_count}, 64'd1);
      bus.mispredict_valid  = 1'b1;
      bus.mispredict_target = 32'h0000_3000;
      tick();
      clear_reqs();
      chk("s1_flush_n2", {63'd0, bus.pipeline_flush}, 64'd1);
      chk("s1_valid_n2", {63'd0, bus.fetch_redirect_valid}, 64'd0);
      tick();
      chk("s1_valid_n3", {63'd0, bus.fetch_redirect_valid}, 64'd1);
      chk("s1_flush_n3", {63'd0, bus.pipeline_flush}, 64'd0);
      chk("s1_addr",     {32'd0, bus.fetch_redirect_addr}, 64'h1000);
      tick();
      chk("s1_done",     {63'd0, bus.busy}, 64'd0);
      chk("s1_count2",   {32'd0, bus.mispredict_count}, 64'd1);

      // Simultaneous trap, mispredict and fence: trap wins.
      push(32'h0000_0080, 2'd3);
      bus.trap_valid        = 1'b1;
      bus.trap_target       = 32'h0000_0080;
      bus.mispredict_valid  = 1'b1;
      bus.mispredict_target = 32'h0000_2000;
      bus.fence_valid       = 1'b1;
      bus.fence_target      = 32'h0000_3000;
      tick();
      clear_reqs();
      wait_idle();
      chk("s2_count", {32'd0, bus.mispredict_count}, 64'd1);

      // Trap during flush reloads the counter and replaces the target.
      push(32'h0000_0080, 2'd3);
      mispredict(32'h0000_1000);
      bus.trap_valid  = 1'b1;
      bus.trap_target = 32'h0000_0080;
      tick();
      clear_reqs();
      chk("s3_flush_a", {63'd0, bus.pipeline_flush}, 64'd1);
      tick();
      chk("s3_flush_b", {63'd0, bus.pipeline_flush}, 64'd1);
      tick();
      chk("s3_valid",   {63'd0, bus.fetch_redirect_valid}, 64'd1);
      wait_idle();
      chk("s3_count",   {32'd0, bus.mispredict_count}, 64'd2);

      // Fetch stalls in REDIRECT, then a trap retargets; odd target gets bit 0 cleared.
      bus.fetch_ready  = 1'b0;
      bus.fence_valid  = 1'b1;
      bus.fence_target = 32'h0000_0501;
      tick();
      clear_reqs();
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("s4_hold_valid", {63'd0, bus.fetch_redirect_valid}, 64'd1);
         chk("s4_hold_addr",  {32'd0, bus.fetch_redirect_addr}, 64'h500);
         chk("s4_hold_cause", {62'd0, bus.fetch_redirect_cause}, 64'd1);
         tick();
      end
      push(32'h0000_0040, 2'd3);
      bus.trap_valid  = 1'b1;
      bus.trap_target = 32'h0000_0040;
      tick();
      clear_reqs();
      chk("s4_drop_valid", {63'd0, bus.fetch_redirect_valid}, 64'd0);
      chk("s4_reflush",    {63'd0, bus.pipeline_flush}, 64'd1);
      bus.fetch_ready = 1'b1;
      wait_idle();

      // Reset in REDIRECT abandons the redirect asynchronously.
      bus.fetch_ready = 1'b0;
      mispredict(32'h0000_0700);
      tick();
      tick();
      chk("s5_in_redirect", {63'd0, bus.fetch_redirect_valid}, 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("s5_async_valid", {63'd0, bus.fetch_redirect_valid}, 64'd0);
      chk("s5_async_addr",  {32'd0, bus.fetch_redirect_addr}, 64'd0);
      chk("s5_async_busy",  {63'd0, bus.busy}, 64'd0);
      chk("s5_async_count", {32'd0, bus.mispredict_count}, 64'd0);
      tick();
      bus.fetch_ready = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s5_no_redirect", {63'd0, bus.busy}, 64'd0);
      end

      // Request on the first edge after reset release.
      rst = 1'b0;
      tick();
      push(32'h0000_0090, 2'd3);
      rst = 1'b1;
      bus.trap_valid  = 1'b1;
      bus.trap_target = 32'h0000_0090;
      tick();
      clear_reqs();
      chk("s6_first_edge", {63'd0, bus.pipeline_flush}, 64'd1);
      wait_idle();

      // Saturation of the mispredict counter.
      force dut.mcount_q = 32'hFFFF_FFFE;
      #1;
      release dut.mcount_q;
      for (int i = 0; i < 3; i++) begin
         push(32'h0000_1000 + 32'(i) * 32'h10, 2'd2);
         mispredict(32'h0000_1000 + 32'(i) * 32'h10);
         chk("s7_sat", {32'd0, bus.mispredict_count}, 64'hFFFF_FFFF);
         wait_idle();
      end

      tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
